// File: rtl/fpa_mul_seq_pkg.sv
// Shared types and constants for the F-PA Booth multiply sequencer.
// State encoding, datapath op codes and step counts live here so the bench and RTL agree.
package fpa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADD   = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [1:0] K_SUM = 2'b00;

    localparam int N_SHORT = 32;
    localparam int N_LONG  = 40;

endpackage

// File: rtl/fpa_mul_seq_if.sv
// Handshake with the FPU microsequencer plus the control word sent to the F-PA datapath.
// The slave modport is the sequencer; the master side is the microsequencer/datapath.
interface fpa_mul_seq_if;

    logic       start;
    logic       len40;
    logic       m39;
    logic       t0;
    logic       t39;
    logic       busy;
    logic       done;
    logic [1:0] t_op;
    logic [1:0] m_op;
    logic [1:0] k_sel;
    logic       alu_sub;
    logic       t_fill;
    logic       m_fill;
    logic [5:0] step;

    modport slave (
        input  start, len40, m39, t0, t39,
        output busy, done, t_op, m_op, k_sel, alu_sub, t_fill, m_fill, step
    );

    modport master (
        output start, len40, m39, t0, t39,
        input  busy, done, t_op, m_op, k_sel, alu_sub, t_fill, m_fill, step
    );

endinterface

// File: rtl/fpa_mul_seq_step_cnt.sv
// Loadable down-counter of remaining Booth steps; flags the last step and reports steps done.
module fpa_step_cnt #(
    parameter int NMAX = 40,
    parameter int CW   = $clog2(NMAX + 1)
) (
    input  logic          clk_sys,
    input  logic          clm,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          tc,
    output logic [CW-1:0] done_cnt
);

    logic [CW-1:0] n_reg;
    logic [CW-1:0] rem;

    // n_reg keeps the requested length so steps done can be derived from what is left
    always_ff @(posedge clk_sys or posedge clm) begin
        if (clm) begin
            n_reg <= '0;
            rem   <= '0;
        end else if (load) begin
            n_reg <= load_val;
            rem   <= load_val;
        end else if (dec && (rem != '0)) begin
            rem <= rem - CW'(1);
        end
    end

    assign tc       = (rem == CW'(1));
    assign done_cnt = n_reg - rem;

endmodule

// File: rtl/fpa_mul_seq.sv
// Booth-1 multiply sequencer: drives the F-PA T/M/K/ALU controls through N add/shift steps,
// leaving the signed 2N-bit product in T:M.
module fpa_mul_seq
    import fpa_seq_pkg::*;
#(
    parameter int NMAX = 40
) (
    input  logic           clk_sys,
    input  logic           clm,
    fpa_mul_seq_if.slave   seq
);

    localparam int CW = $clog2(NMAX + 1);

    state_t        state;
    state_t        state_nxt;
    logic          q;
    logic          cnt_load;
    logic          cnt_tc;
    logic [CW-1:0] cnt_val;
    logic [CW-1:0] cnt_done;

    assign cnt_load = (state == IDLE) && seq.start;
    assign cnt_val  = seq.len40 ? CW'(N_LONG) : CW'(N_SHORT);

    fpa_step_cnt #(.NMAX(NMAX), .CW(CW)) u_cnt (
        .clk_sys  (clk_sys),
        .clm      (clm),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (state == SHIFT),
        .tc       (cnt_tc),
        .done_cnt (cnt_done)
    );

    assign seq.step = 6'(cnt_done);

    always_ff @(posedge clk_sys or posedge clm) begin
        if (clm) state <= IDLE;
        else     state <= state_nxt;
    end

    // Booth history bit: the multiplier LSB that was just shifted out
    always_ff @(posedge clk_sys or posedge clm) begin
        if (clm)                  q <= 1'b0;
        else if (cnt_load)        q <= 1'b0;
        else if (state == SHIFT)  q <= seq.m39;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (seq.start) state_nxt = ADD;
            ADD:     state_nxt = SHIFT;
            SHIFT:   state_nxt = cnt_tc ? DONE : ADD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pair {m39,q}: 10 subtracts C, 01 adds C, equal bits leave T alone
    always_comb begin
        seq.busy    = 1'b0;
        seq.done    = 1'b0;
        seq.t_op    = OP_HOLD;
        seq.m_op    = OP_HOLD;
        seq.k_sel   = K_SUM;
        seq.alu_sub = 1'b0;
        seq.t_fill  = 1'b0;
        seq.m_fill  = 1'b0;
        case (state)
            ADD: begin
                seq.busy = 1'b1;
                if (seq.m39 && !q) begin
                    seq.t_op    = OP_LOAD;
                    seq.alu_sub = 1'b1;
                end else if (!seq.m39 && q) begin
                    seq.t_op    = OP_LOAD;
                end
            end
            SHIFT: begin
                seq.busy   = 1'b1;
                seq.t_op   = OP_SHR;
                seq.m_op   = OP_SHR;
                seq.t_fill = seq.t0;
                seq.m_fill = seq.t39;
            end
            DONE: begin
                seq.busy = 1'b1;
                seq.done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpa_mul_seq.sv
// Bench for fpa_mul_seq: a T/M/C datapath model follows the control word, and the product
// and per-cycle controls are compared with values derived from signed arithmetic and timing.
module tb_fpa_mul_seq;
    import fpa_seq_pkg::*;

    logic        clk_sys;
    logic        clm;
    logic [39:0] mdl_t;
    logic [39:0] mdl_m;
    logic [39:0] mdl_c;
    int          n_cur;
    int          checks;
    int          errors;

    fpa_mul_seq_if bus ();

    fpa_mul_seq #(.NMAX(40)) dut (
        .clk_sys (clk_sys),
        .clm     (clm),
        .seq     (bus)
    );

    assign bus.m39 = mdl_m[0];
    assign bus.t39 = mdl_t[0];
    assign bus.t0  = mdl_t[n_cur-1];

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check_output(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] sext(input logic [39:0] v, input int n);
        logic [79:0] r;
        r = {40'b0, v};
        if (v[n-1]) r = r | ({80{1'b1}} << n);
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_busy"},  80'(bus.busy),    80'(0));
        check_output({tag, "_done"},  80'(bus.done),    80'(0));
        check_output({tag, "_t_op"},  80'(bus.t_op),    80'(0));
        check_output({tag, "_m_op"},  80'(bus.m_op),    80'(0));
        check_output({tag, "_k_sel"}, 80'(bus.k_sel),   80'(0));
        check_output({tag, "_sub"},   80'(bus.alu_sub), 80'(0));
        check_output({tag, "_step"},  80'(bus.step),    80'(0));
        check_output({tag, "_tfill"}, 80'(bus.t_fill),  80'(0));
        check_output({tag, "_mfill"}, 80'(bus.m_fill),  80'(0));
    endtask

    // One complete multiply; stray optionally pulses start at cycles 1, 10, 64 and 65
    task automatic apply_stimulus(input string name, input logic [39:0] c_in, input logic [39:0] m_in,
                                  input logic l40, input bit stray);
        logic [39:0] mask;
        logic [39:0] m_orig;
        logic [39:0] t_nx;
        logic [39:0] m_nx;
        logic [79:0] prod;
        logic [79:0] got;
        logic [1:0]  e_top;
        logic [1:0]  e_mop;
        logic        e_sub;
        logic        b;
        logic        p;
        int          k;
        int          e_step;
        int          busy_cnt;
        int          done_cnt;
        int          done_cyc;
        int          cyc;
        string       tg;

        @(negedge clk_sys);
        n_cur   = l40 ? N_LONG : N_SHORT;
        mask    = {40{1'b1}} >> (40 - n_cur);
        mdl_c   = c_in & mask;
        mdl_m   = m_in & mask;
        mdl_t   = '0;
        m_orig  = mdl_m;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        bus.start = 1'b1;
        bus.len40 = l40;
        @(posedge clk_sys);
        #1;
        cyc = 1;
        bus.start = stray;
        bus.len40 = ~l40;
        while (cyc <= 2*n_cur + 4) begin
            @(negedge clk_sys);
            tg = $sformatf("%s_c%0d", name, cyc);
            e_top = OP_HOLD;
            e_mop = OP_HOLD;
            e_sub = 1'b0;
            e_step = n_cur;
            if (cyc <= 2*n_cur) begin
                k = (cyc - 1) / 2;
                e_step = k;
                if (cyc % 2 == 1) begin
                    b = m_orig[k];
                    p = (k == 0) ? 1'b0 : m_orig[k-1];
                    if (b != p) e_top = OP_LOAD;
                    e_sub = b & ~p;
                end else begin
                    e_top = OP_SHR;
                    e_mop = OP_SHR;
                end
            end
            check_output({tg, "_busy"},  80'(bus.busy),    80'(cyc <= 2*n_cur + 1));
            check_output({tg, "_done"},  80'(bus.done),    80'(cyc == 2*n_cur + 1));
            check_output({tg, "_t_op"},  80'(bus.t_op),    80'(e_top));
            check_output({tg, "_m_op"},  80'(bus.m_op),    80'(e_mop));
            check_output({tg, "_sub"},   80'(bus.alu_sub), 80'(e_sub));
            check_output({tg, "_k_sel"}, 80'(bus.k_sel),   80'(K_SUM));
            check_output({tg, "_step"},  80'(bus.step),    80'(e_step));
            check_output({tg, "_tfill"}, 80'(bus.t_fill),  80'((e_mop == OP_SHR) ? mdl_t[n_cur-1] : 1'b0));
            check_output({tg, "_mfill"}, 80'(bus.m_fill),  80'((e_mop == OP_SHR) ? mdl_t[0] : 1'b0));
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            // Datapath plant: apply whatever control word the sequencer presented
            t_nx = mdl_t;
            m_nx = mdl_m;
            if (bus.t_op == OP_LOAD)
                t_nx = (bus.alu_sub ? (mdl_t - mdl_c) : (mdl_t + mdl_c)) & mask;
            else if (bus.t_op == OP_SHR)
                t_nx = (mdl_t >> 1) | (40'(bus.t_fill) << (n_cur - 1));
            if (bus.m_op == OP_SHR)
                m_nx = (mdl_m >> 1) | (40'(bus.m_fill) << (n_cur - 1));
            @(posedge clk_sys);
            #1;
            mdl_t = t_nx;
            mdl_m = m_nx;
            cyc++;
            bus.start = stray && (cyc == 10 || cyc == 64 || cyc == 65);
            bus.len40 = 1'($urandom_range(0, 1));
        end
        bus.start = 1'b0;
        prod = (sext(c_in & mask, n_cur) * sext(m_orig, n_cur)) & ({80{1'b1}} >> (80 - 2*n_cur));
        got  = ({40'b0, mdl_t} << n_cur) | {40'b0, mdl_m};
        check_output({name, "_product"},   got,             prod);
        check_output({name, "_busy_len"},  80'(busy_cnt),   80'(2*n_cur + 1));
        check_output({name, "_done_cnt"},  80'(done_cnt),   80'(1));
        check_output({name, "_done_cyc"},  80'(done_cyc),   80'(2*n_cur + 1));
    endtask

    task automatic reset_mid_shift();
        bit found;
        found = 1'b0;
        @(negedge clk_sys);
        n_cur = N_SHORT;
        mdl_t = 40'h0_1234_5678;
        mdl_m = 40'h0_9ABC_DEF1;
        bus.start = 1'b1;
        bus.len40 = 1'b0;
        @(posedge clk_sys);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk_sys);
            if (bus.t_op == OP_SHR && bus.step == 6'd7) found = 1'b1;
        end
        check_output("rst_reach_step7", 80'(found), 80'(1));
        #2;
        clm = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        @(posedge clk_sys);
        @(negedge clk_sys);
        clm = 1'b0;
    endtask

    initial begin
        logic [39:0] rc;
        logic [39:0] rm;
        logic        rl;
        checks    = 0;
        errors    = 0;
        n_cur     = N_SHORT;
        mdl_t     = '0;
        mdl_m     = '0;
        mdl_c     = '0;
        bus.start = 1'b0;
        bus.len40 = 1'b0;
        clm       = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_idle_outputs("reset");
        clm = 1'b0;
        @(negedge clk_sys);
        check_idle_outputs("idle");

        reset_mid_shift();
        apply_stimulus("c3m5",  40'd3, 40'd5, 1'b0, 1'b0);
        apply_stimulus("cm7m6", 40'hFF_FFFF_FFF9, 40'd6, 1'b1, 1'b0);
        apply_stimulus("m1",    40'd12345, 40'd1, 1'b0, 1'b0);
        apply_stimulus("stray", {8'h0, $urandom}, {8'h0, $urandom}, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            rl = 1'($urandom_range(0, 1));
            rc = {$urandom, $urandom} & ({40{1'b1}} >> (rl ? 0 : 8));
            rm = {$urandom, $urandom};
            if (rc == (40'd1 << (rl ? 39 : 31))) rc = rc ^ 40'd1;
            apply_stimulus($sformatf("rnd%0d", i), rc, rm, rl, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
